// File: rtl/bitnet_pkg.sv
// Shared types and helpers for the windowed bitstream integrator.
// The ARGMAX state is only entered when BITNET_ARGMAX_EN is defined.
package bitnet_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StCount,
    StArgmax,
    StDone
  } state_e;

  // A zero length selects the full 2^len_w window.
  function automatic logic [31:0] window_cycles(input logic [31:0] len,
                                                input int unsigned len_w);
    if (len == 32'd0) begin
      return 32'd1 << len_w;
    end
    return len;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_window_integrator_if.sv
// Result handshake between the integrator (master) and the readout logic (slave).
// class_idx exists only when BITNET_ARGMAX_EN is defined.
interface stream_window_integrator_if
  import bitnet_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned LEN_W    = 10
);
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned IDX_W = idx_width(CHANNELS);

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] counts [CHANNELS];
`ifdef BITNET_ARGMAX_EN
  logic [IDX_W-1:0] class_idx;

  modport master (output out_valid, output counts, output class_idx, input out_ready);
  modport slave  (input out_valid, input counts, input class_idx, output out_ready);
`else
  modport master (output out_valid, output counts, input out_ready);
  modport slave  (input out_valid, input counts, output out_ready);
`endif

endinterface

// File: rtl/stream_counter.sv
// Per-channel ones counter: synchronous clear, counts din while en is high.
module stream_counter #(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && din) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_window_integrator.sv
// Windowed multi-channel bitstream integrator with warm-up gating and valid/ready result.
// Define BITNET_ARGMAX_EN to add the ARGMAX state and the class_idx output.
module stream_window_integrator
  import bitnet_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned WARMUP   = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    window_len,
  input  logic [CHANNELS-1:0] stream_in,
  output logic                stream_en,
  output logic                busy,
  stream_window_integrator_if.master res
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned WU_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned CYC_W = (CNT_W > WU_W) ? CNT_W : WU_W;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] counts_q [CHANNELS];
  logic [CNT_W-1:0] counts_d [CHANNELS];
  logic [CNT_W-1:0] acc [CHANNELS];
  logic             acc_clear;
  logic             acc_en;
  logic [31:0]      win_full;
  logic [CNT_W-1:0] win;

`ifdef BITNET_ARGMAX_EN
  localparam int unsigned IDX_W = idx_width(CHANNELS);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_q, best_d;
  logic [IDX_W-1:0] class_q, class_d;
  logic [CNT_W-1:0] max_q, max_d;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    stream_counter #(
      .CNT_W(CNT_W)
    ) u_counter (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (acc_clear),
      .en    (acc_en),
      .din   (stream_in[c]),
      .count (acc[c])
    );
  end

  always_comb begin
    win_full = window_cycles(32'(window_len), LEN_W);
    win      = win_full[CNT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    len_d     = len_q;
    counts_d  = counts_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
`ifdef BITNET_ARGMAX_EN
    idx_d     = idx_q;
    best_d    = best_q;
    class_d   = class_q;
    max_d     = max_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d     = win;
          acc_clear = 1'b1;
          if (WARMUP != 0) begin
            state_d = StWarmup;
            cyc_d   = CYC_W'(WARMUP - 1);
          end else begin
            state_d = StCount;
            cyc_d   = CYC_W'(win - 1'b1);
          end
        end
      end

      StWarmup: begin
        if (cyc_q == '0) begin
          state_d = StCount;
          cyc_d   = CYC_W'(len_q - 1'b1);
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end

      StCount: begin
        acc_en = 1'b1;
        if (cyc_q == '0) begin
          // The final sample is still in flight, so fold it in while copying out.
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            counts_d[c] = acc[c] + CNT_W'(stream_in[c]);
          end
`ifdef BITNET_ARGMAX_EN
          state_d = StArgmax;
          idx_d   = '0;
          best_d  = '0;
          max_d   = '0;
`else
          state_d = StDone;
`endif
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end

`ifdef BITNET_ARGMAX_EN
      StArgmax: begin
        // Strict compare keeps the lowest index on ties.
        if (counts_q[idx_q] > max_q) begin
          max_d  = counts_q[idx_q];
          best_d = idx_q;
        end
        if (idx_q == IDX_W'(CHANNELS - 1)) begin
          state_d = StDone;
          class_d = best_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif

      StDone: begin
        if (res.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      len_q    <= '0;
      counts_q <= '{default: '0};
`ifdef BITNET_ARGMAX_EN
      idx_q    <= '0;
      best_q   <= '0;
      class_q  <= '0;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      len_q    <= len_d;
      counts_q <= counts_d;
`ifdef BITNET_ARGMAX_EN
      idx_q    <= idx_d;
      best_q   <= best_d;
      class_q  <= class_d;
      max_q    <= max_d;
`endif
    end
  end

  assign stream_en     = (state_q == StWarmup) || (state_q == StCount);
  assign busy          = (state_q != StIdle);
  assign res.out_valid = (state_q == StDone);
  assign res.counts    = counts_q;
`ifdef BITNET_ARGMAX_EN
  assign res.class_idx = class_q;
`endif

endmodule

// File: tb/tb_stream_window_integrator.sv
// Directed bench for stream_window_integrator (CHANNELS=3, LEN_W=8, WARMUP=4).
// Argmax expectations are compiled in when BITNET_ARGMAX_EN is defined.
module tb_stream_window_integrator;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned WARMUP   = 4;
`ifdef BITNET_ARGMAX_EN
  localparam int ARG_EXTRA = 3;
`else
  localparam int ARG_EXTRA = 0;
`endif

  logic                clk;
  logic                n_rst;
  logic                start;
  logic [LEN_W-1:0]    window_len;
  logic [CHANNELS-1:0] stream_in;
  logic                stream_en;
  logic                busy;

  int vec_cnt;
  int miscompares;

  stream_window_integrator_if #(
    .CHANNELS (CHANNELS),
    .LEN_W    (LEN_W)
  ) bus ();

  stream_window_integrator #(
    .CHANNELS (CHANNELS),
    .LEN_W    (LEN_W),
    .WARMUP   (WARMUP)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .window_len (window_len),
    .stream_in  (stream_in),
    .stream_en  (stream_en),
    .busy       (busy),
    .res        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus for the cycle following edge n after the start edge; bit c drives channel c.
  function automatic logic [2:0] pattern(input int mode, input int n);
    int k;
    k = n - int'(WARMUP);
    case (mode)
      0:       return {(n % 2 == 0), 1'b0, 1'b1};
      1:       return 3'b111;
      2:       return (n < int'(WARMUP)) ? 3'b111 : 3'b000;
      3:       return {(k < 50), (k < 50), (k < 30)};
      default: return 3'b000;
    endcase
  endfunction

  task automatic check_counts(input string tag, input int e0, input int e1, input int e2);
    check_eq({tag, "_c0"}, 32'(bus.counts[0]), e0);
    check_eq({tag, "_c1"}, 32'(bus.counts[1]), e1);
    check_eq({tag, "_c2"}, 32'(bus.counts[2]), e2);
  endtask

  task automatic run_window(input string tag, input logic [7:0] len, input int mode,
                            input int exp_l, input int e0, input int e1, input int e2,
                            input bit hold);
    int n;
    int en_cycles;
    @(posedge clk); #1;
    start         = 1'b1;
    window_len    = len;
    bus.out_ready = !hold;
    @(posedge clk); #1;
    start      = 1'b0;
    window_len = 8'd7;  // must not affect the latched window
    n          = 0;
    en_cycles  = 0;
    while (!bus.out_valid && n < 2000) begin
      stream_in = pattern(mode, n);
      if (stream_en) en_cycles++;
      @(posedge clk); #1;
      n++;
    end
    stream_in = '0;
    check_eq({tag, "_latency"}, n, int'(WARMUP) + exp_l + ARG_EXTRA);
    check_eq({tag, "_en_cycles"}, en_cycles, int'(WARMUP) + exp_l);
    check_eq({tag, "_busy_done"}, 32'(busy), 1);
    check_counts(tag, e0, e1, e2);
    if (!hold) begin
      @(posedge clk); #1;
      check_eq({tag, "_valid_after"}, 32'(bus.out_valid), 0);
      check_eq({tag, "_busy_after"}, 32'(busy), 0);
      check_counts({tag, "_idle_hold"}, e0, e1, e2);
    end
  endtask

  initial begin
    vec_cnt       = 0;
    miscompares   = 0;
    n_rst         = 1'b0;
    start         = 1'b0;
    window_len    = '0;
    stream_in     = '0;
    bus.out_ready = 1'b1;

    #3;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_stream_en", 32'(stream_en), 0);
    check_eq("rst_valid", 32'(bus.out_valid), 0);
    check_counts("rst", 0, 0, 0);
`ifdef BITNET_ARGMAX_EN
    check_eq("rst_class", 32'(bus.class_idx), 0);
`endif
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    run_window("w100", 8'd100, 0, 100, 100, 0, 50, 1'b0);
    run_window("w256", 8'd0, 1, 256, 256, 256, 256, 1'b0);
    run_window("warm_only", 8'd10, 2, 10, 0, 0, 0, 1'b0);

    // Stall in DONE with stray starts.
    run_window("stall", 8'd5, 1, 5, 5, 5, 5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5) || (i == 12);
      @(posedge clk); #1;
      check_eq("stall_valid", 32'(bus.out_valid), 1);
      check_eq("stall_c0", 32'(bus.counts[0]), 5);
    end
    start         = 1'b1;  // coincides with the handshake, must be ignored
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("stall_valid_drop", 32'(bus.out_valid), 0);
    check_eq("stall_busy_drop", 32'(busy), 0);
    @(posedge clk); #1;
    check_eq("stall_no_restart", 32'(busy), 0);

    // Reset in the middle of COUNT.
    @(posedge clk); #1;
    start      = 1'b1;
    window_len = 8'd50;
    @(posedge clk); #1;
    start     = 1'b0;
    stream_in = 3'b111;
    repeat (24) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_stream_en", 32'(stream_en), 0);
    check_eq("abort_valid", 32'(bus.out_valid), 0);
    check_counts("abort", 0, 0, 0);
    stream_in = '0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    run_window("rerun", 8'd20, 1, 20, 20, 20, 20, 1'b0);

    run_window("argmax", 8'd60, 3, 60, 30, 50, 50, 1'b0);
`ifdef BITNET_ARGMAX_EN
    check_eq("argmax_class", 32'(bus.class_idx), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_window_integrator.md
Name: stream_window_integrator

Overview:
Multi-channel, windowed bitstream integrator with a run controller and output handshake. It is the parametrised successor to the free-running per-output integrator at the back end of the bitstream networks. On `start` it gates the upstream network through a warm-up period, during which input bits are discarded. It then counts ones on every channel over a programmable window and presents the counts with valid/ready. It sits between a network's bitstream outputs and the host/readout logic.

Parameters:
- CHANNELS, 3: number of bitstream channels integrated in parallel.
- LEN_W, 10: width of `window_len`; the maximum window is 2^LEN_W cycles.
- WARMUP, 8: cycles discarded after start while the generator/layer pipeline settles; 0 is legal.
- CNT_W, LEN_W+1: localparam, not overridable; count width.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- window_len  input  LEN_W  counting window length in cycles; 0 means 2^LEN_W.
- stream_in  input  CHANNELS  one bitstream bit per channel per cycle.
- stream_en  output  1  high while WARMUP or COUNT; enables the upstream network.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  counts (and class_idx) valid.
- out_ready  input  1  consumer accepts the result.
- counts  output  int [0:CHANNELS-1]  ones count per channel; range 0..2^LEN_W.
- class_idx  output  $clog2(CHANNELS)  winning channel; present only with BITNET_ARGMAX_EN.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low. `clk` and `n_rst` use these exact names.
  - Reset values: state IDLE, `stream_en`=0, `busy`=0, `out_valid`=0, all `counts`=0, `class_idx`=0, accumulators and cycle counter 0.
  - Reset asserted mid-run aborts the run immediately; no partial result is presented.
- States: IDLE -> WARMUP -> COUNT -> [ARGMAX] -> DONE -> IDLE.
- IDLE:
  - `start`=1 latches `window_len` into L (0 maps to 2^LEN_W) and clears the accumulators.
  - Next state is WARMUP, or COUNT directly if WARMUP==0.
- WARMUP: runs for exactly WARMUP cycles; `stream_in` is ignored.
- COUNT:
  - Runs for exactly L cycles; each cycle acc[c] += stream_in[c].
  - After the L-th sample, accumulators are copied to `counts` in the same edge as the exit transition.
- DONE:
  - `out_valid`=1; `counts` are held stable.
  - On `out_valid && out_ready`, go to IDLE; `out_valid` is 0 the following cycle.
- Latency: `start` sampled at edge 0 gives `out_valid` high after edge WARMUP+L. Add CHANNELS cycles when ARGMAX is compiled in.
- Boundary conditions:
  - `start` while busy, including the DONE handshake cycle: ignored. No back-to-back restart without one IDLE cycle.
  - `window_len` changes mid-run: no effect, since L was latched at start.
  - Accumulators cannot overflow: CNT_W holds 2^LEN_W.
  - `counts` keep the last result through IDLE until the next COUNT exit.
  - `out_ready` high outside DONE: no effect.

Optional Feature:
- Macro BITNET_ARGMAX_EN.
- Defined:
  - Adds the `class_idx` port and an ARGMAX state between COUNT and DONE lasting CHANNELS cycles.
  - Each cycle compares one channel against the running maximum; the strict greater-than comparison gives ties to the lowest index.
  - `class_idx` updates together with `out_valid` rising.
- Undefined: no `class_idx` port and no ARGMAX state; COUNT goes directly to DONE.

Decomposition:
- Package bitnet_pkg:
  - state enum (IDLE, WARMUP, COUNT, ARGMAX, DONE);
  - function window_cycles(len, LEN_W) for the 0 -> 2^LEN_W mapping.
- Sub-module stream_counter, one per channel: inputs `clear` and `en`, input `bit`, output CNT_W count.
- The FSM, cycle counter and argmax stay in the top module.

Test Plan:
All scenarios use CHANNELS=3, LEN_W=8, WARMUP=4.
1. `window_len`=100; ch0 constant 1, ch1 constant 0, ch2 toggling from 1 -> `counts`={100,0,50}; `out_valid` rises 104 cycles after the `start` edge; `stream_en` is high for exactly 104 cycles.
2. `window_len`=0, all channels 1 -> `counts`={256,256,256}; COUNT lasts 256 cycles.
3. Ones driven only during the 4 warm-up cycles, zeros afterwards, `window_len`=10 -> `counts`={0,0,0}.
4. `out_ready` held low for 20 cycles in DONE with `start` pulsed twice -> `out_valid` and `counts` held stable, starts ignored; raising `out_ready` returns to IDLE and `busy`=0 on the next cycle.
5. `n_rst` asserted mid-COUNT -> `busy`, `stream_en`, `out_valid` and `counts` go to 0 immediately; a new `start` afterwards completes normally with correct counts.
6. With BITNET_ARGMAX_EN, streams giving {30,50,50} -> `class_idx`=1; `out_valid` is delayed by 3 cycles relative to the non-argmax build.
